ram_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters.
  - Port A: processor data side, single-beat read/write.
  - Port B: read-only burst master, e.g. video/DMA fetch.
- Sits between the requesters and the RAM instance. It drives the RAM's write-enable, address and write-data, and steers the RAM's registered read data back with a valid tag.
- Arbitration is round-robin at transaction granularity. B bursts are non-preemptible, so A's worst-case wait is bounded by MAX_BURST cycles.

---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/ram_port_arbiter_if.sv | 39 +++
 rtl/ram_burst_counter.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter: FSM states,
// grant-owner encoding and the burst-length clamp.
package ram_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  localparam int unsigned MIN_BURST = 32'd1;

  // A zero length still moves one beat; anything above the limit is cut to it.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_beats);
    if (len < MIN_BURST) begin
      return MIN_BURST;
    end else if (len > max_beats) begin
      return max_beats;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the arbiter; slave is the arbiter's
// view, master is the view of the requesters plus the RAM instance.
interface ram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned LEN_WIDTH     = 5
);
  logic                     a_req;
  logic                     a_we;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic                     a_gnt;
  logic                     a_rvalid;
  logic [DATA_WIDTH-1:0]    a_rdata;
  logic                     b_req;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [LEN_WIDTH-1:0]     b_len;
  logic                     b_gnt;
  logic                     b_busy;
  logic                     b_rvalid;
  logic [DATA_WIDTH-1:0]    b_rdata;
  logic                     b_done;
  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_addr, b_len, ram_dataOut,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_busy, b_rvalid, b_rdata, b_done,
    input  ram_wEn, ram_addr, ram_dataIn
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, b_len, ram_dataOut,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_busy, b_rvalid, b_rdata, b_done,
    output ram_wEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/ram_burst_counter.sv
// Burst beat generator: loadable address incrementer plus remaining-beat
// down-counter; last flags the beat that finishes the burst.
module ram_burst_counter #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned LEN_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     step,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]     start_rem,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     last
);

  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]     rem_r;

  // The grant cycle already issued start_addr, so the next beat is start_addr+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {ADDRESS_WIDTH{1'b0}};
      rem_r  <= {LEN_WIDTH{1'b0}};
    end else if (load) begin
      addr_r <= start_addr + ADDRESS_WIDTH'(1);
      rem_r  <= start_rem;
    end else if (step) begin
      addr_r <= addr_r + ADDRESS_WIDTH'(1);
      rem_r  <= rem_r - LEN_WIDTH'(1);
    end else begin
      addr_r <= addr_r;
      rem_r  <= rem_r;
    end
  end

  assign addr = addr_r;
  assign last = (rem_r == LEN_WIDTH'(1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a
// single-beat read/write port A and a non-preemptible read-burst port B.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned LEN_WIDTH     = 5
) (
  input logic               clk,
  input logic               reset_n,
  ram_port_arbiter_if.slave bus
);

  arb_state_e               state_r, state_nxt_s;
  owner_e                   last_grant_r;
  logic [LEN_WIDTH-1:0]     len_eff_s;
  logic                     multi_beat_s, a_win_s, b_win_s;
  logic                     a_gnt_s, b_gnt_s, wen_s, b_issue_s, b_last_s, load_s, step_s;
  logic [ADDRESS_WIDTH-1:0] ram_addr_s, ram_addr_r, cnt_addr_s;
  logic                     cnt_last_s;
  logic                     a_rv_r, b_rv_r, last_r;
  logic [DATA_WIDTH-1:0]    rdata_s;

  assign len_eff_s    = LEN_WIDTH'(clamp_len(32'(bus.b_len), MAX_BURST));
  assign multi_beat_s = (len_eff_s > LEN_WIDTH'(1));
  assign a_win_s      = bus.a_req & (~bus.b_req | (last_grant_r == OWNER_B));
  assign b_win_s      = bus.b_req & ~a_win_s;

  ram_burst_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH)
  ) u_burst_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .step       (step_s),
    .start_addr (bus.b_addr),
    .start_rem  (len_eff_s - LEN_WIDTH'(1)),
    .addr       (cnt_addr_s),
    .last       (cnt_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: only a multi-beat B grant leaves ARB.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB: begin
        if (b_win_s & multi_beat_s) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = ARB;
        end
      end
      BURST: begin
        if (cnt_last_s) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = ARB;
    endcase
  end

  // Output decode: grants and the RAM command for this cycle.
  always_comb begin
    a_gnt_s    = 1'b0;
    b_gnt_s    = 1'b0;
    wen_s      = 1'b0;
    ram_addr_s = ram_addr_r;
    b_issue_s  = 1'b0;
    b_last_s   = 1'b0;
    load_s     = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      ARB: begin
        if (a_win_s) begin
          a_gnt_s    = 1'b1;
          wen_s      = bus.a_we;
          ram_addr_s = bus.a_addr;
        end else if (b_win_s) begin
          b_gnt_s    = 1'b1;
          ram_addr_s = bus.b_addr;
          b_issue_s  = 1'b1;
          b_last_s   = ~multi_beat_s;
          load_s     = multi_beat_s;
        end else begin
          ram_addr_s = ram_addr_r;
        end
      end
      BURST: begin
        ram_addr_s = cnt_addr_s;
        b_issue_s  = 1'b1;
        b_last_s   = cnt_last_s;
        step_s     = 1'b1;
      end
      default: ram_addr_s = ram_addr_r;
    endcase
  end

  // Round-robin history, read-return tags and the idle address hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= OWNER_B;
      a_rv_r       <= 1'b0;
      b_rv_r       <= 1'b0;
      last_r       <= 1'b0;
      ram_addr_r   <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      if (a_gnt_s) begin
        last_grant_r <= OWNER_A;
      end else if (b_last_s) begin
        last_grant_r <= OWNER_B;
      end else begin
        last_grant_r <= last_grant_r;
      end
      a_rv_r     <= a_gnt_s & ~bus.a_we;
      b_rv_r     <= b_issue_s;
      last_r     <= b_last_s;
      ram_addr_r <= ram_addr_s;
    end
  end

  // Strobes that touch the RAM or a requester are killed while reset is held.
  assign bus.a_gnt      = a_gnt_s & reset_n;
  assign bus.b_gnt      = b_gnt_s & reset_n;
  assign bus.ram_wEn    = wen_s & reset_n;
  assign bus.ram_addr   = ram_addr_s;
  assign bus.ram_dataIn = bus.a_wdata;
  assign bus.b_busy     = (b_gnt_s & reset_n) | (state_r == BURST);

  assign rdata_s      = bus.ram_dataOut;
  assign bus.a_rvalid = a_rv_r;
  assign bus.a_rdata  = rdata_s;
  assign bus.b_rvalid = b_rv_r;
  assign bus.b_rdata  = rdata_s;
  assign bus.b_done   = b_rv_r & last_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM, a vector
// table for arbitration decisions and a read-return scoreboard.
module tb_ram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 5;
  localparam int NV = 11;

  typedef struct {
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic [LW-1:0] b_len;
    logic          e_agnt;
    logic          e_bgnt;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic          e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_mis = 0;

  vec_t          vecs [NV];
  logic [DW-1:0] a_q [$];
  logic [DW:0]   b_q [$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  bit            ram_written [0:(1<<AW)-1];

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(16), .LEN_WIDTH(LW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {20'hC0FFE, a};
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  // Single-port synchronous RAM: no read on a write cycle.
  always @(posedge clk) begin
    if (bus.ram_wEn) begin
      ram_mem[bus.ram_addr]     <= bus.ram_dataIn;
      ram_written[bus.ram_addr] <= 1'b1;
    end else begin
      bus.ram_dataOut <= ram_written[bus.ram_addr] ? ram_mem[bus.ram_addr] : pat(bus.ram_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every returned beat must match the head of its queue.
  always @(negedge clk) begin
    if (bus.a_rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_spurious", 64'(bus.a_rvalid), 64'd0);
      else chk("a_rdata", 64'(bus.a_rdata), 64'(a_q.pop_front()));
    end
    if (bus.b_rvalid) begin
      if (b_q.size() == 0) chk("b_rvalid_spurious", 64'(bus.b_rvalid), 64'd0);
      else chk("b_done_rdata", 64'({bus.b_done, bus.b_rdata}), 64'(b_q.pop_front()));
    end else if (bus.b_done) begin
      chk("b_done_without_rvalid", 64'(bus.b_done), 64'd0);
    end
  end

  task automatic settle(input string tag);
    @(negedge clk);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_a_drain"}, 64'(a_q.size()), 64'd0);
    chk({tag, "_b_drain"}, 64'(b_q.size()), 64'd0);
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len, input int beats);
    logic [AW-1:0] ea;
    @(negedge clk);
    bus.a_req  = 1'b0;
    bus.b_req  = 1'b1;
    bus.b_addr = addr;
    bus.b_len  = len;
    #2;
    chk("burst_gnt", 64'({bus.b_gnt, bus.a_gnt, bus.ram_wEn, bus.b_busy, bus.ram_addr}),
        64'({1'b1, 1'b0, 1'b0, 1'b1, addr}));
    b_q.push_back({(beats == 1), exp_word(addr)});
    for (int i = 1; i < beats; i++) begin
      @(negedge clk);
      bus.b_req = 1'b0;
      #2;
      ea = addr + AW'(i);
      chk("burst_beat", 64'({bus.b_gnt, bus.ram_wEn, bus.b_busy, bus.ram_addr}),
          64'({1'b0, 1'b0, 1'b1, ea}));
      b_q.push_back({(i == beats - 1), exp_word(ea)});
    end
    @(negedge clk);
    bus.b_req = 1'b0;
    #2;
    chk("burst_end_busy", 64'(bus.b_busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b1, 12'h010, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 12'h010, 32'h0,        1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b0, 12'h010, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 12'h040, 5'd0, 1'b0, 1'b1, 1'b0, 12'h040, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 12'h011, 32'h0,        1'b1, 12'h050, 5'd1, 1'b1, 1'b0, 1'b0, 12'h011, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 12'h012, 32'h0,        1'b1, 12'h050, 5'd1, 1'b0, 1'b1, 1'b0, 12'h050, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 12'h012, 32'h0,        1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b0, 12'h012, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 1'b0, 12'h012, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 12'h013, 32'h12345678, 1'b1, 12'h060, 5'd1, 1'b0, 1'b1, 1'b0, 12'h060, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 12'h013, 32'h12345678, 1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b1, 12'h013, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 12'h013, 32'h0,        1'b0, 12'h000, 5'd0, 1'b1, 1'b0, 1'b0, 12'h013, 1'b0};

    reset_n     = 1'b0;
    bus.a_req   = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_addr  = 12'h123;
    bus.a_wdata = 32'h55AA55AA;
    bus.b_req   = 1'b1;
    bus.b_addr  = 12'h000;
    bus.b_len   = 5'd1;
    @(negedge clk);
    chk("reset_outputs", 64'({bus.a_gnt, bus.b_gnt, bus.ram_wEn, bus.a_rvalid, bus.b_rvalid, bus.b_done, bus.b_busy}), 64'd0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.a_req   = vecs[i].a_req;
      bus.a_we    = vecs[i].a_we;
      bus.a_addr  = vecs[i].a_addr;
      bus.a_wdata = vecs[i].a_wdata;
      bus.b_req   = vecs[i].b_req;
      bus.b_addr  = vecs[i].b_addr;
      bus.b_len   = vecs[i].b_len;
      #2;
      chk($sformatf("vec%0d", i), 64'({bus.a_gnt, bus.b_gnt, bus.ram_wEn, bus.b_busy, bus.ram_addr}),
          64'({vecs[i].e_agnt, vecs[i].e_bgnt, vecs[i].e_wen, vecs[i].e_busy, vecs[i].e_addr}));
      if (vecs[i].e_wen) chk($sformatf("vec%0d_wdata", i), 64'(bus.ram_dataIn), 64'(vecs[i].a_wdata));
      if (vecs[i].e_agnt && vecs[i].a_we) ref_mem[int'(vecs[i].a_addr)] = vecs[i].a_wdata;
      if (vecs[i].e_agnt && !vecs[i].a_we) a_q.push_back(exp_word(vecs[i].a_addr));
      if (vecs[i].e_bgnt) b_q.push_back({1'b1, exp_word(vecs[i].b_addr)});
    end
    settle("vectors");

    run_burst(12'h020, 5'd4, 4);
    settle("burst4");
    run_burst(12'hFFE, 5'd3, 3);
    settle("wrap");
    run_burst(12'h030, 5'd0, 1);
    settle("len0");
    run_burst(12'h100, 5'd31, 16);
    settle("len31");

    // Contention straight out of reset: A first, then the whole B burst, then A.
    @(negedge clk);
    reset_n    = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b0;
    bus.a_addr = 12'h200;
    bus.b_req  = 1'b1;
    bus.b_addr = 12'h300;
    bus.b_len  = 5'd3;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("cont_a_first", 64'({bus.a_gnt, bus.b_gnt, bus.ram_addr}), 64'({1'b1, 1'b0, 12'h200}));
    a_q.push_back(exp_word(12'h200));
    @(negedge clk);
    bus.a_addr = 12'h201;
    #2;
    chk("cont_b_next", 64'({bus.a_gnt, bus.b_gnt, bus.b_busy, bus.ram_addr}), 64'({1'b0, 1'b1, 1'b1, 12'h300}));
    b_q.push_back({1'b0, exp_word(12'h300)});
    @(negedge clk);
    bus.b_req = 1'b0;
    #2;
    chk("cont_a_wait1", 64'({bus.a_gnt, bus.ram_addr}), 64'({1'b0, 12'h301}));
    b_q.push_back({1'b0, exp_word(12'h301)});
    @(negedge clk);
    #2;
    chk("cont_a_wait2", 64'({bus.a_gnt, bus.ram_addr}), 64'({1'b0, 12'h302}));
    b_q.push_back({1'b1, exp_word(12'h302)});
    @(negedge clk);
    #2;
    chk("cont_a_regrant", 64'({bus.a_gnt, bus.b_busy, bus.ram_addr}), 64'({1'b1, 1'b0, 12'h201}));
    a_q.push_back(exp_word(12'h201));
    settle("contention");

    // Reset lands on beat 2 of an 8-beat burst while A holds a pending write.
    @(negedge clk);
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b0;
    bus.a_addr = 12'h410;
    #2;
    chk("mb_pre_a", 64'(bus.a_gnt), 64'd1);
    a_q.push_back(exp_word(12'h410));
    @(negedge clk);
    bus.a_req  = 1'b0;
    bus.b_req  = 1'b1;
    bus.b_addr = 12'h400;
    bus.b_len  = 5'd8;
    #2;
    chk("mb_gnt", 64'(bus.b_gnt), 64'd1);
    b_q.push_back({1'b0, exp_word(12'h400)});
    @(negedge clk);
    bus.b_req   = 1'b0;
    bus.a_req   = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_addr  = 12'h500;
    bus.a_wdata = 32'h0BADF00D;
    #1;
    chk("mb_beat2", 64'({bus.a_gnt, bus.ram_addr}), 64'({1'b0, 12'h401}));
    reset_n = 1'b0;
    #1;
    chk("mb_reset_force", 64'({bus.ram_wEn, bus.a_gnt, bus.b_gnt}), 64'd0);
    repeat (2) @(negedge clk);
    bus.a_we   = 1'b0;
    bus.b_req  = 1'b1;
    bus.b_addr = 12'h600;
    bus.b_len  = 5'd1;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("post_reset_tie", 64'({bus.a_gnt, bus.b_gnt, bus.ram_addr}), 64'({1'b1, 1'b0, 12'h500}));
    a_q.push_back(exp_word(12'h500));
    @(negedge clk);
    bus.a_req = 1'b0;
    #2;
    chk("post_reset_b", 64'({bus.b_gnt, bus.ram_addr}), 64'({1'b1, 12'h600}));
    b_q.push_back({1'b1, exp_word(12'h600)});
    settle("midburst_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
